// File: rtl/led_matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_matrix_pkg
// Function : Shared types and default dimensions for the LED matrix scanner.
// Revision : 1.0 - initial release
// ============================================================================
package led_matrix_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 8;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    typedef logic [MATRIX_COLS-1:0] row_data_t;

endpackage : led_matrix_pkg
`default_nettype wire

// File: rtl/frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer
// Function : Double-buffered frame store; host writes back, display reads front.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buffer
    import led_matrix_pkg::*;
#(
    parameter int ROWS = MATRIX_ROWS,
    parameter int COLS = MATRIX_COLS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    copy,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [COLS-1:0]         rd_data
);

    localparam int c_row_w = $clog2(ROWS);
    localparam logic [c_row_w:0] c_rows = (c_row_w + 1)'(ROWS);

    logic [COLS-1:0] r_back_q  [ROWS];
    logic [COLS-1:0] r_front_q [ROWS];
    logic [COLS-1:0] w_back_d  [ROWS];
    logic [COLS-1:0] w_front_d [ROWS];

    // Copy reads the pre-write back contents, so a same-edge write only
    // reaches the display at a later swap.
    always_comb begin
        w_back_d  = r_back_q;
        w_front_d = r_front_q;
        if (copy) begin
            w_front_d = r_back_q;
        end
        if (wr_en && ({1'b0, wr_row} < c_rows)) begin
            w_back_d[wr_row] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                r_back_q[i]  <= '0;
                r_front_q[i] <= '0;
            end
        end else begin
            r_back_q  <= w_back_d;
            r_front_q <= w_front_d;
        end
    end

    assign rd_data = r_front_q[rd_row];

endmodule : frame_buffer
`default_nettype wire

// File: rtl/led_row_scanner.sv
`default_nettype none
// ============================================================================
// Module   : led_row_scanner
// Function : Row-multiplexed 8x8 LED driver with inter-row blanking and
//            tear-free frame swaps at frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module led_row_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS         = MATRIX_ROWS,
    parameter int COLS         = MATRIX_COLS,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic [ROWS-1:0]         row_sel,
    output logic [COLS-1:0]         col_out,
    output logic                    frame_start
);

    localparam int c_row_w = $clog2(ROWS);
    localparam int c_cnt_w = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);
    localparam logic [c_row_w-1:0] c_last_row   = c_row_w'(ROWS - 1);

    scan_state_t          r_state_q,       w_state_d;
    logic [c_cnt_w-1:0]   r_blank_cnt_q,   w_blank_cnt_d;
    logic [c_row_w-1:0]   r_row_idx_q,     w_row_idx_d;
    logic                 r_swap_pend_q,   w_swap_pend_d;
    logic                 r_frame_start_q, w_frame_start_d;
    logic                 r_swap_ack_q,    w_swap_ack_d;
    logic                 w_boundary;
    logic                 w_copy;
    logic [COLS-1:0]      w_rd_data;
    logic [ROWS-1:0]      w_row_sel;
    logic [COLS-1:0]      w_col_out;

    always_comb begin
        w_state_d       = r_state_q;
        w_blank_cnt_d   = r_blank_cnt_q;
        w_row_idx_d     = r_row_idx_q;
        w_swap_pend_d   = r_swap_pend_q;
        w_boundary      = 1'b0;
        case (r_state_q)
            BLANK: begin
                if (r_blank_cnt_q == c_blank_last) begin
                    w_state_d     = SHOW;
                    w_blank_cnt_d = '0;
                    w_boundary    = (r_row_idx_q == c_last_row);
                    w_row_idx_d   = w_boundary ? '0 : r_row_idx_q + 1'b1;
                end else begin
                    w_blank_cnt_d = r_blank_cnt_q + 1'b1;
                end
            end
            SHOW: begin
                if (tick) begin
                    w_state_d = BLANK;
                end
            end
            default: w_state_d = BLANK;
        endcase

        // A request arriving on the boundary edge itself is honoured at once.
        w_copy = w_boundary & (r_swap_pend_q | swap_req);
        if (w_copy) begin
            w_swap_pend_d = 1'b0;
        end else if (swap_req) begin
            w_swap_pend_d = 1'b1;
        end
        w_frame_start_d = w_boundary;
        w_swap_ack_d    = w_copy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= BLANK;
            r_blank_cnt_q   <= '0;
            r_row_idx_q     <= c_last_row;
            r_swap_pend_q   <= 1'b0;
            r_frame_start_q <= 1'b0;
            r_swap_ack_q    <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_blank_cnt_q   <= w_blank_cnt_d;
            r_row_idx_q     <= w_row_idx_d;
            r_swap_pend_q   <= w_swap_pend_d;
            r_frame_start_q <= w_frame_start_d;
            r_swap_ack_q    <= w_swap_ack_d;
        end
    end

    frame_buffer #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_frame_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .copy    (w_copy),
        .rd_row  (r_row_idx_q),
        .rd_data (w_rd_data)
    );

    always_comb begin
        w_row_sel = '0;
        w_col_out = '0;
        if (r_state_q == SHOW) begin
            w_row_sel[r_row_idx_q] = 1'b1;
            w_col_out              = w_rd_data;
        end
    end

    assign row_sel     = w_row_sel;
    assign col_out     = w_col_out;
    assign frame_start = r_frame_start_q;
    assign swap_ack    = r_swap_ack_q;

endmodule : led_row_scanner
`default_nettype wire

// File: doc/led_row_scanner.md
Name: led_row_scanner

Overview:
- Consumes the one-cycle rollover pulse from the scan-rate counter and multiplexes an 8x8 LED matrix one row at a time.
- Holds a double-buffered frame: the host writes the back buffer, and the display reads the front buffer.
- Blanks all rows for a fixed number of clocks between rows to suppress ghosting.
- Applies buffer swaps only at frame boundaries, so a frame never tears.

Parameters:
- ROWS, 8, number of matrix rows; must be at least 2.
- COLS, 8, number of matrix columns, which is also the row data width.
- BLANK_CYCLES, 2, clocks with all rows off between consecutive rows; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle pulse from the counter rollover; ends the current row's on-time.
- wr_en  in  1  writes wr_data into the back-buffer row wr_row.
- wr_row  in  $clog2(ROWS)  back-buffer row address.
- wr_data  in  COLS  pixel data; bit c drives column c.
- swap_req  in  1  pulse that requests a back-to-front copy at the next frame boundary.
- swap_ack  out  1  one-cycle pulse; the new frame is visible this cycle.
- row_sel  out  ROWS  one-hot, active-high row drive; all zero while blanking.
- col_out  out  COLS  active-high column drive; zero while blanking.
- frame_start  out  1  one-cycle pulse during the first displayed cycle of row 0.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset state:
  - state = BLANK, blank_cnt = 0, row_idx = ROWS-1.
  - swap_pend = 0.
  - Front and back buffers cleared to 0.
  - All outputs 0.
- Outputs are decoded only from registered state. There is no combinational path from any input to any output.
- FSM, two states:
  - BLANK:
    - row_sel = 0, col_out = 0.
    - blank_cnt increments every clock.
    - When blank_cnt == BLANK_CYCLES-1: go to SHOW, clear blank_cnt, and set row_idx to row_idx+1, wrapping ROWS-1 to 0.
    - tick is ignored in BLANK (it is dropped, not queued).
  - SHOW:
    - row_sel = one-hot of row_idx; col_out = front[row_idx].
    - On tick: go to BLANK. Otherwise stay.
- Start-up latency: row 0 is first driven exactly BLANK_CYCLES clocks after rst deasserts.
- Frame boundary: the BLANK->SHOW edge on which row_idx wraps to 0.
  - frame_start is high during the following cycle.
  - If (swap_pend | swap_req) is set at this edge: front <= back (the full frame in one edge), swap_pend <= 0, and swap_ack is high during that same cycle alongside frame_start.
- Swap request outside a boundary: swap_req sets swap_pend. A repeated swap_req while pending has no further effect, so only one swap occurs.
- Writes:
  - wr_en updates back[wr_row] on the edge; a write never touches front.
  - A write on the same edge as a swap: the copy takes the pre-write back contents, and the new data appears only at a later swap.
  - A wr_row value of ROWS or more is ignored.
- Tick spacing: the tick period must be at least BLANK_CYCLES+1 clocks. Closer ticks are dropped as described above, and each row's on-time stretches to the next accepted tick.
- rst mid-frame: the block returns to the reset state on the next edge. Pending swaps and both buffers are lost, and outputs are 0 the following cycle.

Decomposition:
- Package led_matrix_pkg holds:
  - the scan_state_t enum {BLANK, SHOW};
  - constants MATRIX_ROWS = 8 and MATRIX_COLS = 8, which serve as the parameter defaults;
  - a row_data_t typedef (logic [COLS-1:0]).
- Sub-module frame_buffer holds the back and front register arrays, the write port, and the copy strobe, and provides a row read port. led_row_scanner contains the FSM, swap_pend and output decode.

Test Plan:
- Reset and start-up: hold rst for 3 clocks, then release with tick tied low. Required: all outputs 0 for 2 clocks; then row_sel = 8'b0000_0001, col_out = 0, frame_start = 1 for one cycle.
- Full scan: write back rows r = 0..7 with data 8'h01<<r, pulse swap_req, and drive tick every 6 clocks. Required:
  - swap_ack and frame_start coincide;
  - rows then appear in order 0..7 with col_out = 8'h01<<r;
  - exactly 2 blank cycles (row_sel = 0) separate consecutive rows;
  - row 7 wraps to row 0.
- Deferred swap: pulse swap_req while row 3 is shown, with new back data 8'hAA for all rows. Required: rows 3..7 still show the old data; swap_ack fires at the next row-0 entry; col_out is 8'hAA from that cycle on.
- Write/swap collision: wr_en with wr_row = 0 and wr_data = 8'hFF on the same edge as the swap. Required: row 0 shows the old back value this frame, and 8'hFF only after the next swap.
- Close ticks: apply a tick 1 clock after a previous tick, during BLANK. Required: the second tick is ignored, and the row after the blank stays lit until the next tick.
- Mid-frame reset: assert rst for 1 clock while row 5 is shown and a swap is pending. Required: outputs 0 the next cycle; no swap_ack ever appears; row 0 displays 8'h00 after 2 clocks.
